// File: rtl/dpram_pkg.sv
// Shared types for the dual-port RAM port arbiter.
// Requester id, arbiter states and response-pipeline tag.
package dpram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_rsp_pipe.sv
// Read-response tag pipeline: tracks which requester owns
// each in-flight read and steers RAM read data back to it.
module dpram_rsp_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  rsp_tag_t          issue,
  input  logic [DATA_W-1:0] ram_read,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata
);

  rsp_tag_t          s1;
  rsp_tag_t          s2;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  assign m0_rvalid = s2.valid & (s2.id == 1'b0);
  assign m1_rvalid = s2.valid & (s2.id == 1'b1);

  // RAM data arrives in the same cycle as s2; hold it afterwards
  assign m0_rdata = m0_rvalid ? ram_read : hold0;
  assign m1_rdata = m1_rvalid ? ram_read : hold1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      s1 <= issue;
      s2 <= s1;
      if (m0_rvalid) hold0 <= ram_read;
      if (m1_rvalid) hold1 <= ram_read;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-requester round-robin arbiter with burst lock in
// front of one dual-port RAM port; registered RAM command.
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  input  logic [DATA_W-1:0] ram_read
);

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  arb_state_t state;
  arb_state_t state_nxt;
  req_id_t    last;
  req_id_t    gnt_id;
  req_id_t    own;
  logic       gnt;
  logic [3:0] burst_cnt;
  logic [3:0] cnt_nxt;
  logic       own_req;
  logic       oth_req;
  logic       own_lock;
  logic       sel_we;
  rsp_tag_t   issue;

  assign own      = (state == OWN1);
  assign own_req  = own ? m1_req : m0_req;
  assign oth_req  = own ? m0_req : m1_req;
  assign own_lock = own ? m1_lock : m0_lock;

  always_comb begin
    gnt       = 1'b0;
    gnt_id    = 1'b0;
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          m0_req & m1_req: begin
            gnt    = 1'b1;
            gnt_id = ~last;
          end
          m0_req & ~m1_req: begin
            gnt    = 1'b1;
            gnt_id = 1'b0;
          end
          ~m0_req & m1_req: begin
            gnt    = 1'b1;
            gnt_id = 1'b1;
          end
          default: ;
        endcase
        if (gnt && (gnt_id ? m1_lock : m0_lock)) begin
          state_nxt = gnt_id ? OWN1 : OWN0;
          cnt_nxt   = 4'd1;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_nxt = IDLE;
        end else if (burst_cnt == CAP && oth_req) begin
          // cap reached: hand one slot to the waiting side
          gnt       = 1'b1;
          gnt_id    = ~own;
          state_nxt = IDLE;
        end else begin
          gnt    = 1'b1;
          gnt_id = own;
          if (!own_lock) state_nxt = IDLE;
          else if (burst_cnt != CAP) cnt_nxt = burst_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) gnt = 1'b0;
  end

  assign m0_ack = gnt & ~gnt_id;
  assign m1_ack = gnt & gnt_id;
  assign sel_we = gnt_id ? m1_we : m0_we;

  assign issue.valid = gnt & ~sel_we;
  assign issue.id    = gnt_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_write <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      ram_ce    <= gnt;
      ram_we    <= gnt & sel_we;
      if (gnt) begin
        last      <= gnt_id;
        ram_addr  <= gnt_id ? m1_addr : m0_addr;
        ram_write <= gnt_id ? m1_wdata : m0_wdata;
      end
    end
  end

  dpram_rsp_pipe #(
    .DATA_W(DATA_W)
  ) u_rsp (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .ram_read (ram_read),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata)
  );

endmodule
